// File: rtl/traffic_pkg.sv
// Shared encodings for the intersection controller: operating modes,
// legacy manual lamp commands and the FSM state set.
package traffic_pkg;

    localparam logic [1:0] MODE_AUTO   = 2'd0;
    localparam logic [1:0] MODE_FLASH  = 2'd1;
    localparam logic [1:0] MODE_HOLD   = 2'd2;
    localparam logic [1:0] MODE_MANUAL = 2'd3;

    localparam logic [1:0] CMD_RED    = 2'd0;
    localparam logic [1:0] CMD_YELLOW = 2'd1;
    localparam logic [1:0] CMD_GREEN  = 2'd2;

    typedef enum logic [2:0] {
        ST_ALLRED = 3'd0,
        ST_GREEN  = 3'd1,
        ST_YELLOW = 3'd2,
        ST_FLASH  = 3'd3,
        ST_HOLD   = 3'd4,
        ST_MANUAL = 3'd5
    } state_t;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/rr_next_dir.sv
// Round-robin search for the next approach with demand, starting just after
// the approach that currently holds green; the active approach is never chosen.
module rr_next_dir #(
    parameter int NUM_DIR = 4
) (
    input  logic [NUM_DIR-1:0]         demand,
    input  logic [$clog2(NUM_DIR)-1:0] active_dir,
    output logic                       found,
    output logic [$clog2(NUM_DIR)-1:0] next_dir
);

    localparam int DW = $clog2(NUM_DIR);

    logic [DW-1:0] idx;

    always_comb begin
        found    = 1'b0;
        next_dir = active_dir;
        idx      = '0;
        for (int i = 1; i < NUM_DIR; i++) begin
            idx = DW'((int'(active_dir) + i) % NUM_DIR);
            if (!found && demand[idx]) begin
                found    = 1'b1;
                next_dir = idx;
            end
        end
    end

endmodule

// File: rtl/traffic_light_ctrl.sv
// Timed intersection controller: round-robin green with yellow and all-red
// clearance, plus flashing-yellow, all-red hold and manual lamp modes.
module traffic_light_ctrl
    import traffic_pkg::*;
#(
    parameter int NUM_DIR    = 4,
    parameter int GREEN_CYC  = 8,
    parameter int YELLOW_CYC = 3,
    parameter int ALLRED_CYC = 2,
    parameter int FLASH_HALF = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [1:0]                 mode,
    input  logic [NUM_DIR-1:0]         demand,
    input  logic [$clog2(NUM_DIR)-1:0] man_sel,
    input  logic [1:0]                 man_cmd,
    output logic [NUM_DIR-1:0]         red,
    output logic [NUM_DIR-1:0]         yellow,
    output logic [NUM_DIR-1:0]         green,
    output logic [$clog2(NUM_DIR)-1:0] active_dir,
    output logic [2:0]                 state_o
);

    localparam int DW   = $clog2(NUM_DIR);
    localparam int TMAX = max2(max2(GREEN_CYC, YELLOW_CYC), max2(ALLRED_CYC, FLASH_HALF));
    localparam int TW   = $clog2(TMAX + 1);

    state_t        state, state_nxt;
    logic [TW-1:0] timer, timer_nxt;
    logic [DW-1:0] next_dir, next_dir_nxt, active_nxt;
    logic          flash_on, flash_nxt;
    logic          expired;
    logic          found;
    logic [DW-1:0] rr_dir;
    logic [NUM_DIR-1:0] red_nxt, yellow_nxt, green_nxt;

    rr_next_dir #(.NUM_DIR(NUM_DIR)) u_rr (
        .demand     (demand),
        .active_dir (active_dir),
        .found      (found),
        .next_dir   (rr_dir)
    );

    // Timer parks at 1 so a green past its minimum keeps re-checking demand.
    assign expired = (timer == TW'(1));
    assign state_o = state;

    always_comb begin
        state_nxt    = state;
        timer_nxt    = (timer > TW'(1)) ? timer - TW'(1) : timer;
        active_nxt   = active_dir;
        next_dir_nxt = next_dir;
        flash_nxt    = flash_on;
        case (state)
            ST_ALLRED: begin
                if (expired) begin
                    if (mode == MODE_AUTO) begin
                        state_nxt  = ST_GREEN;
                        timer_nxt  = TW'(GREEN_CYC);
                        active_nxt = next_dir;
                    end else if (mode == MODE_FLASH) begin
                        state_nxt = ST_FLASH;
                        timer_nxt = TW'(FLASH_HALF);
                        flash_nxt = 1'b1;
                    end else if (mode == MODE_HOLD) begin
                        state_nxt = ST_HOLD;
                    end else begin
                        state_nxt = ST_MANUAL;
                    end
                end
            end
            ST_GREEN: begin
                if (expired && found) next_dir_nxt = rr_dir;
                if (mode != MODE_AUTO || (expired && found)) begin
                    state_nxt = ST_YELLOW;
                    timer_nxt = TW'(YELLOW_CYC);
                end
            end
            ST_YELLOW: begin
                if (expired) begin
                    state_nxt = ST_ALLRED;
                    timer_nxt = TW'(ALLRED_CYC);
                end
            end
            ST_FLASH: begin
                if (mode != MODE_FLASH) begin
                    state_nxt = ST_ALLRED;
                    timer_nxt = TW'(ALLRED_CYC);
                end else if (expired) begin
                    flash_nxt = !flash_on;
                    timer_nxt = TW'(FLASH_HALF);
                end
            end
            ST_HOLD: begin
                if (mode != MODE_HOLD) begin
                    state_nxt = ST_ALLRED;
                    timer_nxt = TW'(ALLRED_CYC);
                end
            end
            ST_MANUAL: begin
                if (mode != MODE_MANUAL) begin
                    state_nxt = ST_ALLRED;
                    timer_nxt = TW'(ALLRED_CYC);
                end
            end
            default: begin
                state_nxt = ST_ALLRED;
                timer_nxt = TW'(ALLRED_CYC);
            end
        endcase
    end

    // Lamps are decoded from the next state so they change with the state register.
    always_comb begin
        red_nxt    = '1;
        yellow_nxt = '0;
        green_nxt  = '0;
        case (state_nxt)
            ST_GREEN: begin
                red_nxt[active_nxt]   = 1'b0;
                green_nxt[active_nxt] = 1'b1;
            end
            ST_YELLOW: begin
                red_nxt[active_nxt]    = 1'b0;
                yellow_nxt[active_nxt] = 1'b1;
            end
            ST_FLASH: begin
                red_nxt    = '0;
                yellow_nxt = {NUM_DIR{flash_nxt}};
            end
            ST_MANUAL: begin
                if (int'(man_sel) < NUM_DIR) begin
                    if (man_cmd == CMD_YELLOW) begin
                        red_nxt[man_sel]    = 1'b0;
                        yellow_nxt[man_sel] = 1'b1;
                    end else if (man_cmd >= CMD_GREEN) begin
                        red_nxt[man_sel]   = 1'b0;
                        green_nxt[man_sel] = 1'b1;
                    end else if (man_cmd == CMD_RED) begin
                        red_nxt[man_sel] = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_ALLRED;
            timer      <= TW'(ALLRED_CYC);
            active_dir <= '0;
            next_dir   <= '0;
            flash_on   <= 1'b0;
            red        <= '1;
            yellow     <= '0;
            green      <= '0;
        end else begin
            state      <= state_nxt;
            timer      <= timer_nxt;
            active_dir <= active_nxt;
            next_dir   <= next_dir_nxt;
            flash_on   <= flash_nxt;
            red        <= red_nxt;
            yellow     <= yellow_nxt;
            green      <= green_nxt;
        end
    end

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Scoreboard bench: expected lamp/state snapshots are queued per cycle and
// compared on the falling edge when that cycle comes round.
module tb_traffic_light_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] mode = 2'd0;
    logic [3:0] demand = 4'd0;
    logic [1:0] man_sel = 2'd0;
    logic [1:0] man_cmd = 2'd0;
    logic [3:0] red, yellow, green;
    logic [1:0] active_dir;
    logic [2:0] state_o;

    traffic_light_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .mode       (mode),
        .demand     (demand),
        .man_sel    (man_sel),
        .man_cmd    (man_cmd),
        .red        (red),
        .yellow     (yellow),
        .green      (green),
        .active_dir (active_dir),
        .state_o    (state_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        int         k;
        logic [3:0] r, y, g;
        logic [1:0] ad;
        logic [2:0] st;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   cyc = 0;
    int   base = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int k, input logic [3:0] r, input logic [3:0] y,
                        input logic [3:0] g, input logic [1:0] ad, input logic [2:0] st);
        exp_t e;
        e.cyc = base + k; e.k = k;
        e.r = r; e.y = y; e.g = g; e.ad = ad; e.st = st;
        sb.push_back(e);
    endtask

    task automatic go(input int k);
        while (cyc < base + k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        base = cyc;
    endtask

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            cur = sb.pop_front();
            chk($sformatf("c%0d_red", cur.k), {28'd0, red}, {28'd0, cur.r});
            chk($sformatf("c%0d_yellow", cur.k), {28'd0, yellow}, {28'd0, cur.y});
            chk($sformatf("c%0d_green", cur.k), {28'd0, green}, {28'd0, cur.g});
            chk($sformatf("c%0d_active_dir", cur.k), {30'd0, active_dir}, {30'd0, cur.ad});
            chk($sformatf("c%0d_state", cur.k), {29'd0, state_o}, {29'd0, cur.st});
        end
    end

    initial begin
        int n;
        // no demand: green settles on approach 0 and stays there
        do_reset();
        push(0, 4'hF, 4'h0, 4'h0, 2'd0, 3'd0);
        push(1, 4'hF, 4'h0, 4'h0, 2'd0, 3'd0);
        push(2, 4'hE, 4'h0, 4'h1, 2'd0, 3'd1);
        push(9, 4'hE, 4'h0, 4'h1, 2'd0, 3'd1);
        push(20, 4'hE, 4'h0, 4'h1, 2'd0, 3'd1);
        push(40, 4'hE, 4'h0, 4'h1, 2'd0, 3'd1);
        go(41);

        do_reset();
        push(2, 4'hE, 4'h0, 4'h1, 2'd0, 3'd1);
        push(9, 4'hE, 4'h0, 4'h1, 2'd0, 3'd1);
        push(10, 4'hE, 4'h1, 4'h0, 2'd0, 3'd2);
        push(12, 4'hE, 4'h1, 4'h0, 2'd0, 3'd2);
        push(13, 4'hF, 4'h0, 4'h0, 2'd0, 3'd0);
        push(14, 4'hF, 4'h0, 4'h0, 2'd0, 3'd0);
        push(15, 4'hB, 4'h0, 4'h4, 2'd2, 3'd1);
        push(22, 4'hB, 4'h0, 4'h4, 2'd2, 3'd1);
        push(23, 4'hB, 4'h4, 4'h0, 2'd2, 3'd2);
        push(26, 4'hF, 4'h0, 4'h0, 2'd2, 3'd0);
        push(28, 4'h7, 4'h0, 4'h8, 2'd3, 3'd1);
        push(35, 4'h7, 4'h0, 4'h8, 2'd3, 3'd1);
        push(36, 4'h7, 4'h8, 4'h0, 2'd3, 3'd2);
        push(39, 4'hF, 4'h0, 4'h0, 2'd3, 3'd0);
        push(40, 4'hF, 4'h0, 4'h0, 2'd3, 3'd0);
        push(41, 4'hE, 4'h0, 4'h1, 2'd0, 3'd1);
        push(49, 4'hE, 4'h1, 4'h0, 2'd0, 3'd2);
        push(52, 4'hF, 4'h0, 4'h0, 2'd0, 3'd0);
        push(54, 4'hD, 4'h0, 4'h2, 2'd1, 3'd1);
        push(58, 4'hD, 4'h0, 4'h2, 2'd1, 3'd1);
        push(59, 4'hD, 4'h2, 4'h0, 2'd1, 3'd2);
        push(61, 4'hD, 4'h2, 4'h0, 2'd1, 3'd2);
        push(62, 4'hF, 4'h0, 4'h0, 2'd1, 3'd0);
        push(63, 4'hF, 4'h0, 4'h0, 2'd1, 3'd0);
        push(64, 4'h0, 4'hF, 4'h0, 2'd1, 3'd3);
        push(67, 4'h0, 4'hF, 4'h0, 2'd1, 3'd3);
        push(68, 4'h0, 4'h0, 4'h0, 2'd1, 3'd3);
        push(71, 4'h0, 4'h0, 4'h0, 2'd1, 3'd3);
        push(72, 4'h0, 4'hF, 4'h0, 2'd1, 3'd3);
        push(76, 4'h0, 4'h0, 4'h0, 2'd1, 3'd3);
        push(77, 4'hF, 4'h0, 4'h0, 2'd1, 3'd0);
        push(78, 4'hF, 4'h0, 4'h0, 2'd1, 3'd0);
        push(79, 4'hD, 4'h0, 4'h2, 2'd1, 3'd1);
        push(81, 4'hD, 4'h2, 4'h0, 2'd1, 3'd2);
        push(84, 4'hF, 4'h0, 4'h0, 2'd1, 3'd0);
        push(85, 4'hF, 4'h0, 4'h0, 2'd1, 3'd0);
        push(86, 4'hF, 4'h0, 4'h0, 2'd1, 3'd5);
        push(87, 4'hB, 4'h4, 4'h0, 2'd1, 3'd5);
        push(88, 4'hB, 4'h0, 4'h4, 2'd1, 3'd5);
        push(89, 4'hB, 4'h0, 4'h4, 2'd1, 3'd5);
        push(90, 4'hF, 4'h0, 4'h0, 2'd1, 3'd5);
        push(91, 4'hF, 4'h0, 4'h0, 2'd1, 3'd0);
        push(92, 4'hF, 4'h0, 4'h0, 2'd1, 3'd0);
        push(93, 4'hD, 4'h0, 4'h2, 2'd1, 3'd1);
        push(100, 4'hD, 4'h0, 4'h2, 2'd1, 3'd1);
        push(101, 4'hD, 4'h2, 4'h0, 2'd1, 3'd2);
        push(102, 4'hF, 4'h0, 4'h0, 2'd0, 3'd0);
        push(103, 4'hF, 4'h0, 4'h0, 2'd0, 3'd0);
        push(104, 4'hE, 4'h0, 4'h1, 2'd0, 3'd1);

        go(5);   demand = 4'b0100;
        go(15);  demand = 4'b1000;
        go(28);  demand = 4'b0011;
        go(41);  demand = 4'b0010;
        go(54);  demand = 4'b0000;
        go(58);  mode = 2'd1;
        go(76);  mode = 2'd0;
        go(80);  mode = 2'd3; man_sel = 2'd2; man_cmd = 2'd0;
        go(86);  man_cmd = 2'd1;
        go(87);  man_cmd = 2'd2;
        go(88);  man_cmd = 2'd3;
        go(89);  man_cmd = 2'd0;
        go(90);  mode = 2'd0;
        go(93);  demand = 4'b0001;
        go(101); reset = 1'b1;
        go(102); reset = 1'b0;
        go(105);

        n = 0;
        while (sb.size() > 0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        if (sb.size() != 0) chk("drain_timeout", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
